// File: rtl/mult_datapath.sv
// Shift-and-add datapath for the sequential multiplier: operand shifters, product
// accumulator, step counter and an acknowledged result register.
module mult_datapath #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   input  logic                 a_sel,
   input  logic                 b_sel,
   input  logic                 prod_sel,
   input  logic                 add_sel,
   input  logic                 hold,
   input  logic                 ack,
   output logic                 b_lsb,
   output logic                 b_zero,
   output logic                 count_done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_valid
);

   localparam int unsigned     CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);

   logic [2*WIDTH-1:0] a_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH-1:0]   b_reg;
   logic [CW-1:0]      cnt;
   logic               saturated;
   logic               step_en;
   logic               capture;

   always_comb begin
      saturated = prod_sel && (cnt == CNT_MAX);
      step_en   = prod_sel && (cnt != CNT_MAX);
      prod_next = prod_reg + (add_sel ? a_reg : '0);
      // Capture on the step that takes the counter from WIDTH-1 to WIDTH.
      capture   = !hold && step_en && (cnt == CNT_MAX - CW'(1));
   end

   // Saturation freezes every datapath register, including the operand shifters.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         prod_reg <= '0;
         cnt      <= '0;
      end else if (!hold && !saturated) begin
         a_reg <= a_sel ? (a_reg << 1) : {{WIDTH{1'b0}}, operand_a};
         b_reg <= b_sel ? (b_reg >> 1) : operand_b;
         if (!prod_sel) begin
            prod_reg <= '0;
            cnt      <= '0;
         end else begin
            prod_reg <= prod_next;
            cnt      <= cnt + CW'(1);
         end
      end
   end

   // A capture on the same edge as ack wins, so result_valid stays set.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else if (capture) begin
         result       <= prod_next;
         result_valid <= 1'b1;
      end else if (ack) begin
         result_valid <= 1'b0;
      end
   end

   assign b_lsb      = b_reg[0];
   assign b_zero     = (b_reg == '0);
   assign count_done = (cnt == CNT_MAX);

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: a small FSM model drives the selects and
// every output is compared against hand-computed products.
module tb_mult_datapath;

   localparam int unsigned WIDTH = 32;

   logic                 Clock;
   logic                 Reset_n;
   logic [WIDTH-1:0]     operand_a;
   logic [WIDTH-1:0]     operand_b;
   logic                 a_sel;
   logic                 b_sel;
   logic                 prod_sel;
   logic                 add_sel;
   logic                 hold;
   logic                 ack;
   logic                 b_lsb;
   logic                 b_zero;
   logic                 count_done;
   logic [2*WIDTH-1:0]   result;
   logic                 result_valid;

   int n_cmp = 0;
   int n_err = 0;
   logic add_seen;

   mult_datapath #(.WIDTH(WIDTH)) dut (
      .Clock        (Clock),
      .Reset_n      (Reset_n),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .a_sel        (a_sel),
      .b_sel        (b_sel),
      .prod_sel     (prod_sel),
      .add_sel      (add_sel),
      .hold         (hold),
      .ack          (ack),
      .b_lsb        (b_lsb),
      .b_zero       (b_zero),
      .count_done   (count_done),
      .result       (result),
      .result_valid (result_valid)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge Clock);
      a_sel = 1'b0; b_sel = 1'b0; prod_sel = 1'b0; add_sel = 1'b0;
      hold = 1'b0; ack = 1'b0;
      operand_a = a; operand_b = b;
      @(posedge Clock);
      #1;
   endtask

   // FSM model: add_sel follows b_lsb within the same cycle.
   task automatic run_steps(input int n, input logic ack_v);
      repeat (n) begin
         @(negedge Clock);
         a_sel = 1'b1; b_sel = 1'b1; prod_sel = 1'b1; hold = 1'b0;
         ack = ack_v;
         add_sel = b_lsb;
         if (b_lsb) add_seen = 1'b1;
         @(posedge Clock);
      end
      #1;
   endtask

   task automatic idle_cycles(input int n, input logic ack_v);
      repeat (n) begin
         @(negedge Clock);
         a_sel = 1'b1; b_sel = 1'b1; prod_sel = 1'b1; hold = 1'b1;
         add_sel = 1'b1; ack = ack_v;
         @(posedge Clock);
      end
      #1;
   endtask

   initial begin
      Reset_n = 1'b0;
      operand_a = '0; operand_b = '0;
      a_sel = 1'b0; b_sel = 1'b0; prod_sel = 1'b0; add_sel = 1'b0;
      hold = 1'b0; ack = 1'b0;
      add_seen = 1'b0;
      #12;
      check("rst_b_lsb", 64'(b_lsb), 64'd0);
      check("rst_b_zero", 64'(b_zero), 64'd1);
      check("rst_count_done", 64'(count_done), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_valid", 64'(result_valid), 64'd0);
      Reset_n = 1'b1;

      // 3 * 5
      load_ops(32'd3, 32'd5);
      check("basic_load_b_lsb", 64'(b_lsb), 64'd1);
      check("basic_load_b_zero", 64'(b_zero), 64'd0);
      run_steps(31, 1'b0);
      check("basic_31_done", 64'(count_done), 64'd0);
      check("basic_31_valid", 64'(result_valid), 64'd0);
      run_steps(1, 1'b0);
      check("basic_result", result, 64'd15);
      check("basic_valid", 64'(result_valid), 64'd1);
      check("basic_done", 64'(count_done), 64'd1);
      idle_cycles(1, 1'b1);
      check("basic_ack_valid", 64'(result_valid), 64'd0);
      check("basic_ack_result", result, 64'd15);

      // Maximum operands, then extra steps while saturated
      load_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_steps(32, 1'b0);
      check("max_result", result, 64'hFFFF_FFFE_0000_0001);
      check("max_valid", 64'(result_valid), 64'd1);
      run_steps(3, 1'b0);
      check("max_extra_result", result, 64'hFFFF_FFFE_0000_0001);
      check("max_extra_done", 64'(count_done), 64'd1);
      idle_cycles(1, 1'b1);

      // Zero multiplier
      load_ops(32'h1234_5678, 32'd0);
      check("zero_b_zero", 64'(b_zero), 64'd1);
      check("zero_b_lsb", 64'(b_lsb), 64'd0);
      add_seen = 1'b0;
      run_steps(32, 1'b0);
      check("zero_add_seen", 64'(add_seen), 64'd0);
      check("zero_result", result, 64'd0);
      check("zero_valid", 64'(result_valid), 64'd1);
      idle_cycles(1, 1'b1);

      // 7 * 9 with 5 hold cycles after step 10: 37 cycles of run time
      load_ops(32'd7, 32'd9);
      run_steps(10, 1'b0);
      idle_cycles(5, 1'b0);
      check("hold_done", 64'(count_done), 64'd0);
      check("hold_valid", 64'(result_valid), 64'd0);
      run_steps(21, 1'b0);
      check("hold_31_valid", 64'(result_valid), 64'd0);
      check("hold_31_done", 64'(count_done), 64'd0);
      run_steps(1, 1'b0);
      check("hold_result", result, 64'd63);
      check("hold_valid_end", 64'(result_valid), 64'd1);

      // Handshake: result held without ack, new load leaves it alone
      idle_cycles(20, 1'b0);
      check("hs_wait_valid", 64'(result_valid), 64'd1);
      check("hs_wait_result", result, 64'd63);
      load_ops(32'd6, 32'd7);
      check("hs_load_result", result, 64'd63);
      check("hs_load_valid", 64'(result_valid), 64'd1);
      run_steps(31, 1'b0);
      check("hs_31_result", result, 64'd63);
      run_steps(1, 1'b1);
      check("hs_cap_ack_result", result, 64'd42);
      check("hs_cap_ack_valid", 64'(result_valid), 64'd1);

      // Reset pulse between edges mid-run
      load_ops(32'd11, 32'd13);
      run_steps(16, 1'b0);
      check("rr_pre_valid", 64'(result_valid), 64'd1);
      check("rr_pre_result", result, 64'd42);
      #1 Reset_n = 1'b0;
      #1;
      check("rr_result", result, 64'd0);
      check("rr_valid", 64'(result_valid), 64'd0);
      check("rr_b_zero", 64'(b_zero), 64'd1);
      check("rr_b_lsb", 64'(b_lsb), 64'd0);
      check("rr_done", 64'(count_done), 64'd0);
      #1 Reset_n = 1'b1;
      load_ops(32'd2, 32'd4);
      run_steps(32, 1'b0);
      check("rr_rerun_result", result, 64'd8);
      check("rr_rerun_valid", 64'(result_valid), 64'd1);

      // ack with nothing pending is a no-op
      idle_cycles(1, 1'b1);
      idle_cycles(1, 1'b1);
      check("ack_idle_valid", 64'(result_valid), 64'd0);
      check("ack_idle_result", result, 64'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
